tia_audio_gen: RTL and testbench
================================

Name: tia_audio_gen

Overview:
- Parametrised TIA-style audio generator: NUM_CH independent tone channels, each built from real polynomial counters (poly4/poly5/poly9) and divide chains, with no per-mode pattern ROMs.
- Adds a register write port, per-channel 4-bit volume, and a registered mixed output.
- Sits between the CPU/TIA register decode and the audio DAC path.
- Runs on the system clock; the ~31 kHz audio rate arrives as a TICK enable, not as a separate clock.

Parameters:
- NUM_CH, 2: number of channels, 1..8.
- FREQ_W, 5: AUDF width (frequency divider width).
- VOL_W, 4: AUDV width.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- TICK  in  1  one-CLK audio-rate enable.
- WR_EN  in  1  register write strobe.
- WR_CH  in  max(1,$clog2(NUM_CH))  channel select.
- WR_REG  in  2  register select: 0=AUDC, 1=AUDF, 2=AUDV, 3=ignored.
- WR_DATA  in  8  write data; low bits used.
- AUD_BIT  out  NUM_CH  raw 1-bit tone per channel.
- AUD_LEVEL  out  NUM_CH*VOL_W  per-channel level; channel n occupies bits [n*VOL_W +: VOL_W].
- AUD_MIX  out  VOL_W+$clog2(NUM_CH+1)  sum of all levels.

Behaviour:
Reset (async, RESET_N=0):
- AUDC=0, AUDF=0, AUDV=0, freq counter=0.
- poly4=4'hF, poly5=5'h1F, poly9=9'h1FF, div31=0, div3=0.
- AUD_BIT=0, AUD_LEVEL=0, AUD_MIX=0.

Writes:
- A write occurs on a CLK edge with WR_EN=1, and the new value is visible from the next cycle.
- A write with WR_CH>=NUM_CH, or WR_REG=3, is ignored.
- A write on the same edge as a step has no effect on that step; the step uses the old register values.

Divider, per channel, on each TICK:
- If counter==AUDF: counter<=0 and a "step" occurs.
- Otherwise counter<=counter+1, wrapping modulo 2^FREQ_W.
- If AUDF is written below the current count, the counter runs up to its wrap and back to 0 before it can match.

Generators: all shift right, and the output is bit0.
- poly4: new bit3 = b0^b1.
- poly5: new bit4 = b0^b2.
- poly9: new bit8 = b0^b4.
- div3 counts 0..2; "d3wrap" means a 2->0 transition.
- div31 counts 0..30; "d31wrap" means a 30->0 transition.
- sq31 = (div31<18).

On each step, by AUDC mode:
- Defaults: poly5, poly9 and div3 advance. div31 advances, except in mode E where it advances only on d3wrap. AUD_BIT is held unless the mode below says otherwise.
- 0,B: AUD_BIT<=1.
- 1: poly4 advances; AUD_BIT<=poly4 b0 pre-shift. Period 15.
- 2: poly4 advances only on d31wrap; AUD_BIT<=poly4 b0. Period 465.
- 3: poly4 advances only when poly5 b0==1; AUD_BIT<=poly4 b0.
- 4,5: AUD_BIT<=~AUD_BIT. Period 2.
- 6,A: AUD_BIT<=sq31. Period 31, 18 high.
- 7,9: AUD_BIT<=poly5 b0. Period 31.
- 8: AUD_BIT<=poly9 b0. Period 511.
- C,D: AUD_BIT toggles on d3wrap. Period 6.
- E: AUD_BIT<=sq31, with div31 gated by d3wrap. Period 93.
- F: poly5 advances only on d3wrap; AUD_BIT<=poly5 b0. Period 93.

Mode changes:
- Writing AUDC does not disturb generator state; the new mode applies from the next step.
- Generators idle between steps.

Output pipeline:
- AUD_LEVEL[n] is registered: AUD_BIT[n] ? AUDV[n] : 0, one CLK after AUD_BIT or AUDV changes.
- AUD_MIX is registered: the full-width sum of the AUD_LEVEL fields, one CLK after AUD_LEVEL. It never overflows.

Reset mid-operation:
- Everything returns to reset values immediately.
- The first step after release uses counter=0.

Optional Feature:
- Macro AUDIO_RESYNC_EN.
- Defined: any AUDC write to a channel also reloads that channel's freq counter, poly4/5/9, div3 and div31 to their reset values on the same edge. AUD_BIT is unchanged. Waveforms are therefore phase-deterministic after a mode change.
- Undefined: AUDC writes touch only AUDC, as in Behaviour.

Test Plan:
- Reset, then AUDC0=4, AUDF0=0, AUDV0=F, TICK every cycle -> AUD_BIT[0] toggles every TICK from 0. AUD_LEVEL[0] alternates F/0 one CLK later. AUD_MIX=F/0 one further CLK later.
- AUDC0=1, AUDF0=2 -> AUD_BIT[0] changes only on every 3rd TICK and repeats with a 15-step period: sequence 1,1,1,1,0,0,0,1,0,0,1,1,0,1,0.
- AUDC0=8, AUDF0=0 -> 511-step period. Over one period, AUD_BIT has exactly 256 ones.
- Both channels: AUDC=6/C, AUDV=F/7 -> AUD_MIX in {0,7,F,0x16}. Channel 1 has period 6; channel 0 has 18 high / 13 low.
- WR_CH=2 with NUM_CH=2, WR_REG=3 writes, and a write coincident with a step -> ignored writes cause no change. The coincident step uses the old AUDF/AUDC.
- AUDC mode 1 run for 7 steps, then rewrite AUDC=1 -> without AUDIO_RESYNC_EN the sequence continues from step 8. With it defined, the sequence restarts at step 1. Also assert RESET_N mid-tone -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/tia_audio_gen.sv
// rtl/tia_audio_gen.sv - TIA-style multi-channel tone generator with poly counters, volume and mix
// Optional macro AUDIO_RESYNC_EN: an AUDC write also reloads that channel's divider and generators.
module tia_audio_gen #(
  parameter int NUM_CH = 2,
  parameter int FREQ_W = 5,
  parameter int VOL_W  = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int MIX_W = VOL_W + $clog2(NUM_CH + 1)
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    TICK,
  input  logic                    WR_EN,
  input  logic [CH_W-1:0]         WR_CH,
  input  logic [1:0]              WR_REG,
  input  logic [7:0]              WR_DATA,
  output logic [NUM_CH-1:0]       AUD_BIT,
  output logic [NUM_CH*VOL_W-1:0] AUD_LEVEL,
  output logic [MIX_W-1:0]        AUD_MIX
);

  logic             unused_wr;
  logic [MIX_W-1:0] mix_sum;

  assign unused_wr = &{1'b0, WR_DATA};

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [3:0]        audc;
    logic [FREQ_W-1:0] audf;
    logic [FREQ_W-1:0] cnt;
    logic [VOL_W-1:0]  audv;
    logic [VOL_W-1:0]  level;
    logic [3:0]        poly4;
    logic [4:0]        poly5;
    logic [8:0]        poly9;
    logic [1:0]        div3;
    logic [4:0]        div31;
    logic              aud_bit;
    logic              sel;
    logic              step;
    logic              d3wrap;
    logic              d31wrap;
    logic              sq31;
    logic              p4_adv;
    logic              p5_adv;
    logic              d31_adv;
    logic              bit_nxt;

    assign sel     = WR_EN && (WR_CH == CH_W'(n));
    assign step    = TICK && (cnt == audf);
    assign d3wrap  = (div3 == 2'd2);
    assign d31wrap = (div31 == 5'd30);
    assign sq31    = (div31 < 5'd18);

    // Mode decode: which generators advance on a step and where the tone bit comes from.
    always_comb begin
      p4_adv  = 1'b0;
      p5_adv  = 1'b1;
      d31_adv = 1'b1;
      bit_nxt = aud_bit;
      case (audc)
        4'h0, 4'hB: bit_nxt = 1'b1;
        4'h1: begin
          p4_adv  = 1'b1;
          bit_nxt = poly4[0];
        end
        4'h2: begin
          p4_adv  = d31wrap;
          bit_nxt = poly4[0];
        end
        4'h3: begin
          p4_adv  = poly5[0];
          bit_nxt = poly4[0];
        end
        4'h4, 4'h5: bit_nxt = ~aud_bit;
        4'h6, 4'hA: bit_nxt = sq31;
        4'h7, 4'h9: bit_nxt = poly5[0];
        4'h8:       bit_nxt = poly9[0];
        4'hC, 4'hD: bit_nxt = aud_bit ^ d3wrap;
        4'hE: begin
          d31_adv = d3wrap;
          bit_nxt = sq31;
        end
        4'hF: begin
          p5_adv  = d3wrap;
          bit_nxt = poly5[0];
        end
        default: bit_nxt = aud_bit;
      endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        audc    <= '0;
        audf    <= '0;
        audv    <= '0;
        cnt     <= '0;
        poly4   <= 4'hF;
        poly5   <= 5'h1F;
        poly9   <= 9'h1FF;
        div3    <= '0;
        div31   <= '0;
        aud_bit <= 1'b0;
        level   <= '0;
      end else begin
        if (sel && WR_REG == 2'd0) audc <= WR_DATA[3:0];
        if (sel && WR_REG == 2'd1) audf <= WR_DATA[FREQ_W-1:0];
        if (sel && WR_REG == 2'd2) audv <= WR_DATA[VOL_W-1:0];
        if (TICK) cnt <= step ? '0 : cnt + 1'b1;
        if (step) begin
          aud_bit <= bit_nxt;
          if (p4_adv) poly4 <= {poly4[0] ^ poly4[1], poly4[3:1]};
          if (p5_adv) poly5 <= {poly5[0] ^ poly5[2], poly5[4:1]};
          poly9 <= {poly9[0] ^ poly9[4], poly9[8:1]};
          div3  <= d3wrap ? 2'd0 : div3 + 2'd1;
          if (d31_adv) div31 <= d31wrap ? 5'd0 : div31 + 5'd1;
        end
`ifdef AUDIO_RESYNC_EN
        // Reload overrides any coincident step so the new mode starts from a known phase.
        if (sel && WR_REG == 2'd0) begin
          cnt   <= '0;
          poly4 <= 4'hF;
          poly5 <= 5'h1F;
          poly9 <= 9'h1FF;
          div3  <= '0;
          div31 <= '0;
        end
`else
`endif
        level <= aud_bit ? audv : '0;
      end
    end

    assign AUD_BIT[n]                  = aud_bit;
    assign AUD_LEVEL[n*VOL_W +: VOL_W] = level;
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mix_sum = mix_sum + MIX_W'(AUD_LEVEL[i*VOL_W +: VOL_W]);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) AUD_MIX <= '0;
    else          AUD_MIX <= mix_sum;
  end

endmodule

// File: tb/tb_tia_audio_gen.sv
// tb/tb_tia_audio_gen.sv - self-checking bench for tia_audio_gen
module tb_tia_audio_gen;
  localparam int NCH  = 3;
  localparam int FW   = 5;
  localparam int VW   = 4;
  localparam int CHW  = 2;
  localparam int MIXW = 6;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              TICK;
  logic              WR_EN;
  logic [CHW-1:0]    WR_CH;
  logic [1:0]        WR_REG;
  logic [7:0]        WR_DATA;
  logic [NCH-1:0]    AUD_BIT;
  logic [NCH*VW-1:0] AUD_LEVEL;
  logic [MIXW-1:0]   AUD_MIX;

  int cmp_n = 0;
  int err_n = 0;

  tia_audio_gen #(.NUM_CH(NCH), .FREQ_W(FW), .VOL_W(VW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .TICK(TICK), .WR_EN(WR_EN), .WR_CH(WR_CH),
    .WR_REG(WR_REG), .WR_DATA(WR_DATA), .AUD_BIT(AUD_BIT), .AUD_LEVEL(AUD_LEVEL),
    .AUD_MIX(AUD_MIX)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    cmp_n++;
    if (act != exp) begin
      err_n++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: integer state, one tone channel per array slot.
  int m_audc[NCH], m_audf[NCH], m_audv[NCH], m_cnt[NCH];
  int m_p4[NCH], m_p5[NCH], m_p9[NCH], m_d3[NCH], m_d31[NCH];
  int m_bit[NCH], m_lvl[NCH];
  int m_mix;

  function automatic int shift_lfsr(input int v, input int w, input int tap);
    return (v >> 1) | (((v ^ (v >> tap)) & 1) << (w - 1));
  endfunction

  task automatic model_reset_gens(input int c);
    m_cnt[c] = 0; m_p4[c] = 15; m_p5[c] = 31; m_p9[c] = 511; m_d3[c] = 0; m_d31[c] = 0;
  endtask

  task automatic model_step(input int c);
    int mode, p4, p5, p9, d3, d31;
    bit wrap3, wrap31;
    mode = m_audc[c]; p4 = m_p4[c]; p5 = m_p5[c]; p9 = m_p9[c]; d3 = m_d3[c]; d31 = m_d31[c];
    wrap3 = (d3 == 2); wrap31 = (d31 == 30);
    case (mode)
      0, 11:     m_bit[c] = 1;
      1, 2, 3:   m_bit[c] = p4 & 1;
      4, 5:      m_bit[c] = 1 - m_bit[c];
      6, 10, 14: m_bit[c] = (d31 < 18) ? 1 : 0;
      7, 9, 15:  m_bit[c] = p5 & 1;
      8:         m_bit[c] = p9 & 1;
      12, 13:    if (wrap3) m_bit[c] = 1 - m_bit[c];
      default:   ;
    endcase
    if (mode == 1 || (mode == 2 && wrap31) || (mode == 3 && (p5 & 1) == 1))
      m_p4[c] = shift_lfsr(p4, 4, 1);
    if (mode != 15 || wrap3) m_p5[c] = shift_lfsr(p5, 5, 2);
    m_p9[c] = shift_lfsr(p9, 9, 4);
    m_d3[c] = (d3 + 1) % 3;
    if (mode != 14 || wrap3) m_d31[c] = (d31 + 1) % 31;
  endtask

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int c = 0; c < NCH; c++) begin
        m_audc[c] = 0; m_audf[c] = 0; m_audv[c] = 0; m_bit[c] = 0; m_lvl[c] = 0;
        model_reset_gens(c);
      end
      m_mix = 0;
    end else begin
      m_mix = 0;
      for (int c = 0; c < NCH; c++) m_mix += m_lvl[c];
      for (int c = 0; c < NCH; c++) m_lvl[c] = m_bit[c] ? m_audv[c] : 0;
      if (TICK) begin
        for (int c = 0; c < NCH; c++) begin
          if (m_cnt[c] == m_audf[c]) begin
            m_cnt[c] = 0;
            model_step(c);
          end else begin
            m_cnt[c] = (m_cnt[c] + 1) % (1 << FW);
          end
        end
      end
      if (WR_EN && int'(WR_CH) < NCH && WR_REG != 2'd3) begin
        case (WR_REG)
          2'd0: begin
            m_audc[WR_CH] = WR_DATA[3:0];
`ifdef AUDIO_RESYNC_EN
            model_reset_gens(int'(WR_CH));
`else
`endif
          end
          2'd1: m_audf[WR_CH] = WR_DATA[FW-1:0];
          default: m_audv[WR_CH] = WR_DATA[VW-1:0];
        endcase
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge CLK) begin
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("bit[%0d]", c), int'(AUD_BIT[c]), m_bit[c]);
      chk($sformatf("level[%0d]", c), int'(AUD_LEVEL[c*VW +: VW]), m_lvl[c]);
    end
    chk("mix", int'(AUD_MIX), m_mix);
  end

  task automatic cyc(input logic t);
    TICK = t;
    @(negedge CLK);
    TICK = 1'b0;
  endtask

  task automatic wr(input int ch, input int rg, input int data, input logic t);
    WR_EN = 1'b1; WR_CH = CHW'(ch); WR_REG = 2'(rg); WR_DATA = 8'(data); TICK = t;
    @(negedge CLK);
    WR_EN = 1'b0; TICK = 1'b0;
  endtask

  int seq15[15] = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0};
  int b0[200], b1[200], mx[200];
  int ones, bad, idx;

  initial begin
    RESET_N = 1'b0; TICK = 1'b0; WR_EN = 1'b0; WR_CH = '0; WR_REG = '0; WR_DATA = '0;
    #1;
    chk("reset_bit", int'(AUD_BIT), 0);
    chk("reset_level", int'(AUD_LEVEL), 0);
    chk("reset_mix", int'(AUD_MIX), 0);
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Mode 4 toggle with pipeline latency
    wr(0, 0, 4, 0); wr(0, 1, 0, 0); wr(0, 2, 15, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      chk($sformatf("t1_bit_k%0d", k), int'(AUD_BIT[0]), k & 1);
      chk($sformatf("t1_lvl_k%0d", k), int'(AUD_LEVEL[3:0]), ((k & 1) == 0) ? 15 : 0);
      chk($sformatf("t1_mix_k%0d", k), int'(AUD_MIX), ((k & 1) == 1 && k >= 3) ? 15 : 0);
    end

    // Mode 1, AUDF=2: step every 3rd tick, 15-long sequence
    wr(0, 0, 1, 0); wr(0, 1, 2, 0);
    for (int j = 0; j < 15; j++) begin
      cyc(1); cyc(1); cyc(1);
      chk($sformatf("t2_seq_%0d", j), int'(AUD_BIT[0]), seq15[j]);
    end

    // Mode 8: 511-step period has 256 ones
    wr(0, 0, 8, 0); wr(0, 1, 0, 0);
    ones = 0;
    for (int k = 0; k < 511; k++) begin
      cyc(1);
      ones += int'(AUD_BIT[0]);
    end
    chk("t3_poly9_ones", ones, 256);

    // Two channels: mode 6 (vol F) and mode C (vol 7)
    wr(0, 0, 6, 0); wr(1, 0, 12, 0); wr(1, 2, 7, 0);
    for (int k = 0; k < 186; k++) begin
      cyc(1);
      b0[k] = int'(AUD_BIT[0]); b1[k] = int'(AUD_BIT[1]); mx[k] = int'(AUD_MIX);
    end
    bad = 0;
    for (int k = 3; k < 186; k++)
      if (!(mx[k] == 0 || mx[k] == 7 || mx[k] == 15 || mx[k] == 22)) bad++;
    chk("t4_mix_set", bad, 0);
    ones = 0;
    for (int k = 0; k < 31; k++) ones += b0[k];
    chk("t4_ch0_high", ones, 18);
    ones = 0;
    for (int k = 0; k < 6; k++) ones += b1[k];
    chk("t4_ch1_high", ones, 3);
    bad = 0;
    for (int k = 0; k < 180; k++) if (b1[k] != b1[k+6]) bad++;
    chk("t4_ch1_period6", bad, 0);
    bad = 0;
    for (int k = 0; k < 155; k++) if (b0[k] != b0[k+31]) bad++;
    chk("t4_ch0_period31", bad, 0);

    // Ignored writes
    wr(3, 2, 0, 0); wr(0, 3, 0, 0); wr(1, 3, 0, 0);
    cyc(0); cyc(0);
    chk("t5_lvl0_kept", int'(AUD_LEVEL[3:0]), AUD_BIT[0] ? 15 : 0);
    chk("t5_lvl1_kept", int'(AUD_LEVEL[7:4]), AUD_BIT[1] ? 7 : 0);

    // Writes coincident with a step use the old register values
    wr(0, 0, 4, 0);
    if (AUD_BIT[0] == 1'b0) cyc(1);
    chk("t5_prep_bit", int'(AUD_BIT[0]), 1);
    wr(0, 0, 0, 1);
    chk("t5_coinc_audc", int'(AUD_BIT[0]), 0);
    wr(0, 1, 5, 1);
    chk("t5_coinc_audf", int'(AUD_BIT[0]), 1);

    // Mode 1 rewrite after 7 steps
    wr(0, 1, 0, 0); wr(0, 0, 1, 0);
    for (int j = 0; j < 7; j++) begin
      cyc(1);
      chk($sformatf("t6_pre_%0d", j), int'(AUD_BIT[0]), seq15[j]);
    end
    wr(0, 0, 1, 0);
    for (int j = 0; j < 8; j++) begin
      cyc(1);
`ifdef AUDIO_RESYNC_EN
      idx = j;
`else
      idx = 7 + j;
`endif
      chk($sformatf("t6_post_%0d", j), int'(AUD_BIT[0]), seq15[idx]);
    end

    // Asynchronous reset mid-tone
    wr(0, 2, 15, 0);
    cyc(1); cyc(1); cyc(1);
    #2 RESET_N = 1'b0;
    #1;
    chk("t7_async_bit", int'(AUD_BIT), 0);
    chk("t7_async_level", int'(AUD_LEVEL), 0);
    chk("t7_async_mix", int'(AUD_MIX), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    wr(0, 0, 4, 0); wr(0, 2, 15, 0);
    cyc(1);
    chk("t7_first_step", int'(AUD_BIT[0]), 1);
    wr(0, 1, 1, 0);
    cyc(1);
    chk("t7_no_step", int'(AUD_BIT[0]), 1);
    cyc(1);
    chk("t7_step_audf1", int'(AUD_BIT[0]), 0);
    cyc(0); cyc(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
